sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Downstream consumer of the sprite command/handshake stage. On a one-cycle `blitter_start` it copies an x_size × y_size rectangle of 16-bit pixels from sprite memory into the framebuffer at (dest_x, dest_y), then pulses `blitter_finished`.
- Sits between the command stage, the sprite-memory read port and the framebuffer write port.
- Pixels falling outside the screen are clipped, i.e. no write is issued for them.

Parameters:
- SCREEN_W, 640, framebuffer width in pixels; row stride for address generation.
- SCREEN_H, 480, framebuffer height in pixels.
- FB_AW, 19, framebuffer word-address width.
- TRANSPARENT_COLOR, 16'hF81F, key colour; used only with BLIT_TRANSPARENCY_EN.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- blitter_start  in  1  one-cycle start pulse from the command stage
- sprite_address  in  26  word address of sprite pixel (0,0); row-major, no padding
- x_size  in  10  sprite width in pixels
- y_size  in  10  sprite height in pixels
- dest_x  in  10  screen X of sprite top-left
- dest_y  in  10  screen Y of sprite top-left
- rd_req  out  1  one-cycle read request to sprite memory
- rd_addr  out  26  read word address
- rd_data  in  16  read data
- rd_valid  in  1  rd_data valid; exactly one per rd_req, latency ≥1 cycle
- fb_write  out  1  framebuffer write strobe
- fb_address  out  FB_AW  framebuffer word address
- fb_writedata  out  16  pixel value
- fb_waitrequest  in  1  framebuffer stall
- blitter_finished  out  1  one-cycle done pulse
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - All outputs 0 and state IDLE.
  - Internal row, col and source address 0; latched command registers 0.
- Reset mid-operation:
  - Aborts the transfer immediately.
  - No `blitter_finished` pulse is issued.
  - A write in progress is dropped.
- States: IDLE, READ_REQ, READ_WAIT, WRITE, NEXT, DONE.
- IDLE:
  - On `blitter_start`, latch `sprite_address`, `x_size`, `y_size`, `dest_x`, `dest_y`; set row=0, col=0, src=sprite_address.
  - If x_size==0 or y_size==0, go to DONE with no memory traffic; otherwise go to READ_REQ.
- READ_REQ: `rd_req`=1 for exactly this cycle, `rd_addr`=src; then READ_WAIT.
- READ_WAIT: hold until `rd_valid`; capture `rd_data` into the pixel register; then WRITE.
- WRITE:
  - px = dest_x+col and py = dest_y+row, each computed at 11 bits.
  - If px ≥ SCREEN_W or py ≥ SCREEN_H, the pixel is clipped: `fb_write` stays 0 and the FSM goes to NEXT on the next cycle.
  - Otherwise drive `fb_write`=1, `fb_address`=py*SCREEN_W+px truncated to FB_AW, and `fb_writedata`=pixel. Hold all three stable while `fb_waitrequest`=1; go to NEXT on the first cycle with `fb_waitrequest`=0.
- NEXT:
  - src increments by 1.
  - If col==x_size-1: col=0 and row increments; otherwise col increments.
  - If col==x_size-1 and row==y_size-1, go to DONE; else go to READ_REQ.
- DONE: `blitter_finished`=1 for one cycle; then IDLE.
- Start handling: `blitter_start` is ignored in every state other than IDLE, including DONE; it is not queued.
- Latency: minimum 4 cycles per unclipped pixel (READ_REQ, READ_WAIT with 1-cycle read, WRITE, NEXT), plus added rd_valid latency and waitrequest cycles.
- Timing of busy vs. done: `busy` falls in the cycle after the `blitter_finished` pulse.
- Address arithmetic: row/col counters are 10 bits. The 26-bit src wraps modulo 2^26.

Optional Feature:
- Macro: BLIT_TRANSPARENCY_EN.
- Defined: in WRITE, a captured pixel equal to TRANSPARENT_COLOR is treated like a clipped pixel. No `fb_write` is issued, and the FSM goes to NEXT on the next cycle.
- Undefined: every on-screen pixel is written, including TRANSPARENT_COLOR. The parameter is unused.

Test Plan:
- 2×2 sprite:
  - Stimulus: sprite_address=0x100, dest=(10,20), memory returns 0x1111..0x4444, no stalls.
  - Required: writes at 12810, 12811, 13450, 13451 with data in order; `blitter_finished` pulse exactly once; `busy` low afterwards.
- Zero width:
  - Stimulus: x_size=0, y_size=5, start.
  - Required: no `rd_req`, no `fb_write`; `blitter_finished` 2 cycles after start.
- Clipping:
  - Stimulus: dest=(638,479), 4×2 sprite.
  - Required: 8 `rd_req`; exactly 2 writes, at addresses 307198 and 307199; done pulse.
- Stalls:
  - Stimulus: `fb_waitrequest` high 3 cycles on each write; `rd_valid` latency 2.
  - Required: address and data held stable while stalled; no write duplicated or lost.
- Reset and ignored start:
  - Stimulus: Reset_n low mid-way through an 8×8 blit.
  - Required: all outputs 0 asynchronously; no done pulse. A fresh blit afterwards completes correctly.
  - Stimulus: second `blitter_start` while busy.
  - Required: ignored.
- Transparency:
  - Stimulus: with BLIT_TRANSPARENCY_EN, 1×3 sprite of {0x0001, 0xF81F, 0x0003}.
  - Required: writes at col 0 and col 2 only.
  - Without the macro: 3 writes.

Source files
------------

// File: rtl/sprite_blitter.sv
// ----------------------------------------------------------------------------
// sprite_blitter
//   Copies an x_size x y_size rectangle of 16-bit pixels from sprite memory to
//   the framebuffer at (dest_x, dest_y). Each pixel goes through four steps:
//   read request, wait for the read data, framebuffer write, then advance the
//   counters. Pixels that land off-screen are clipped (no write is issued).
//
//   Optional feature macro: BLIT_TRANSPARENCY_EN
//     When defined, pixels equal to TRANSPARENT_COLOR are skipped like
//     clipped pixels. When undefined, every on-screen pixel is written.
//
// Ports
//   Clk, Reset_n        clock, asynchronous active-low reset
//   blitter_start       one-cycle start pulse (accepted only when idle)
//   sprite_address      word address of sprite pixel (0,0), row-major
//   x_size, y_size      sprite dimensions in pixels
//   dest_x, dest_y      screen position of the sprite's top-left pixel
//   rd_req/rd_addr      one-cycle sprite-memory read request
//   rd_data/rd_valid    read response, one per request
//   fb_write/fb_address/fb_writedata/fb_waitrequest  framebuffer write port
//   blitter_finished    one-cycle done pulse
//   busy                high whenever the FSM is not idle
// ----------------------------------------------------------------------------
module sprite_blitter #(
   parameter int          SCREEN_W          = 640,
   parameter int          SCREEN_H          = 480,
   parameter int          FB_AW             = 19,
   parameter logic [15:0] TRANSPARENT_COLOR = 16'hF81F
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             blitter_start,
   input  logic [25:0]      sprite_address,
   input  logic [9:0]       x_size,
   input  logic [9:0]       y_size,
   input  logic [9:0]       dest_x,
   input  logic [9:0]       dest_y,
   output logic             rd_req,
   output logic [25:0]      rd_addr,
   input  logic [15:0]      rd_data,
   input  logic             rd_valid,
   output logic             fb_write,
   output logic [FB_AW-1:0] fb_address,
   output logic [15:0]      fb_writedata,
   input  logic             fb_waitrequest,
   output logic             blitter_finished,
   output logic             busy
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      READ_REQ  = 3'd1,
      READ_WAIT = 3'd2,
      WRITE     = 3'd3,
      NEXT      = 3'd4,
      DONE      = 3'd5
   } state_t;

   localparam logic [10:0]      SW11 = 11'(SCREEN_W);
   localparam logic [10:0]      SH11 = 11'(SCREEN_H);
   localparam logic [FB_AW-1:0] SWFB = FB_AW'(SCREEN_W);

   state_t      state, state_nx;

   logic [9:0]  xs_q, ys_q, dx_q, dy_q;
   logic [9:0]  row, col;
   logic [25:0] src;
   logic [15:0] pixel;

   logic [10:0]      px, py;
   logic             clip, transparent, skip;
   logic             last_col, last_row;
   logic [FB_AW-1:0] fb_lin;

   // Screen position of the current pixel; 11 bits so dest+col cannot wrap.
   assign px = {1'b0, dx_q} + {1'b0, col};
   assign py = {1'b0, dy_q} + {1'b0, row};
   assign clip = (px >= SW11) || (py >= SH11);

   // Arithmetic done directly at FB_AW bits: identical to truncating the
   // full-width product, without carrying unused upper bits around.
   assign fb_lin = FB_AW'(py) * SWFB + FB_AW'(px);

`ifdef BLIT_TRANSPARENCY_EN
   assign transparent = (pixel == TRANSPARENT_COLOR);
`else
   logic unused_tc;
   assign unused_tc   = ^TRANSPARENT_COLOR;
   assign transparent = 1'b0;
`endif

   assign skip     = clip || transparent;
   assign last_col = (col == xs_q - 10'd1);
   assign last_row = (row == ys_q - 10'd1);

   // ---------------- state register ----------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:
            if (blitter_start)
               state_nx = (x_size == 10'd0 || y_size == 10'd0) ? DONE : READ_REQ;
         READ_REQ:  state_nx = READ_WAIT;
         READ_WAIT: if (rd_valid) state_nx = WRITE;
         // A skipped pixel never touches the bus, so the stall is irrelevant.
         WRITE:     if (skip || !fb_waitrequest) state_nx = NEXT;
         NEXT:      state_nx = (last_col && last_row) ? DONE : READ_REQ;
         DONE:      state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   // Data outputs are gated by their strobes so everything reads 0 when idle.
   always_comb begin
      rd_req           = (state == READ_REQ);
      rd_addr          = 26'd0;
      fb_write         = (state == WRITE) && !skip;
      fb_address       = '0;
      fb_writedata     = 16'd0;
      blitter_finished = (state == DONE);
      busy             = (state != IDLE);
      if (rd_req) rd_addr = src;
      if (fb_write) begin
         fb_address   = fb_lin;
         fb_writedata = pixel;
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         xs_q  <= 10'd0;
         ys_q  <= 10'd0;
         dx_q  <= 10'd0;
         dy_q  <= 10'd0;
         row   <= 10'd0;
         col   <= 10'd0;
         src   <= 26'd0;
         pixel <= 16'd0;
      end else begin
         case (state)
            IDLE:
               if (blitter_start) begin
                  xs_q <= x_size;
                  ys_q <= y_size;
                  dx_q <= dest_x;
                  dy_q <= dest_y;
                  row  <= 10'd0;
                  col  <= 10'd0;
                  src  <= sprite_address;
               end
            READ_WAIT:
               if (rd_valid) pixel <= rd_data;
            NEXT: begin
               src <= src + 26'd1;
               if (last_col) begin
                  col <= 10'd0;
                  row <= row + 10'd1;
               end else begin
                  col <= col + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

   localparam int W  = 640;
   localparam int H  = 480;
   localparam int AW = 19;

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic          blitter_start = 1'b0;
   logic [25:0]   sprite_address = '0;
   logic [9:0]    x_size = '0, y_size = '0, dest_x = '0, dest_y = '0;
   logic          rd_req;
   logic [25:0]   rd_addr;
   logic [15:0]   rd_data = '0;
   logic          rd_valid = 1'b0;
   logic          fb_write;
   logic [AW-1:0] fb_address;
   logic [15:0]   fb_writedata;
   logic          fb_waitrequest = 1'b0;
   logic          blitter_finished;
   logic          busy;

   sprite_blitter #(.SCREEN_W(W), .SCREEN_H(H), .FB_AW(AW), .TRANSPARENT_COLOR(16'hF81F)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .blitter_start(blitter_start),
      .sprite_address(sprite_address), .x_size(x_size), .y_size(y_size),
      .dest_x(dest_x), .dest_y(dest_y), .rd_req(rd_req), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .fb_write(fb_write),
      .fb_address(fb_address), .fb_writedata(fb_writedata),
      .fb_waitrequest(fb_waitrequest), .blitter_finished(blitter_finished),
      .busy(busy)
   );

   always #5 Clk = ~Clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // ---------------- memory / framebuffer models ----------------
   logic [15:0]   mem [0:1023];
   int            cyc = 0;
   int            rd_cnt = 0, fin_cnt = 0, fin_cyc = 0;
   int            rd_lat = 1, stall_n = 0, rcnt = 0, scnt = 0;
   logic [9:0]    raddr_q = '0;
   logic          stalling = 1'b0, prev_fin = 1'b0;
   logic [AW-1:0] hold_a = '0;
   logic [15:0]   hold_d = '0;
   logic [AW-1:0] wr_addr_q [$];
   logic [15:0]   wr_data_q [$];

   always @(posedge Clk) cyc = cyc + 1;

   always @(negedge Clk) begin
      if (!Reset_n) begin
         rcnt = 0; rd_valid = 1'b0; fb_waitrequest = 1'b0;
         stalling = 1'b0; prev_fin = 1'b0; scnt = stall_n;
      end else begin
         // read port: one response rd_lat cycles after each request
         if (rcnt > 0) begin
            rcnt--;
            if (rcnt == 0) begin rd_valid = 1'b1; rd_data = mem[raddr_q]; end
         end else rd_valid = 1'b0;
         if (rd_req) begin rd_cnt++; rcnt = rd_lat; raddr_q = rd_addr[9:0]; end
         // write port: stall each write stall_n cycles, log the accepted one
         if (fb_write) begin
            if (stalling) begin
               chk("stall_hold_addr", 32'(fb_address), 32'(hold_a));
               chk("stall_hold_data", 32'(fb_writedata), 32'(hold_d));
            end
            if (scnt > 0) begin
               fb_waitrequest = 1'b1; scnt--; stalling = 1'b1;
               hold_a = fb_address; hold_d = fb_writedata;
            end else begin
               fb_waitrequest = 1'b0; stalling = 1'b0; scnt = stall_n;
               wr_addr_q.push_back(fb_address);
               wr_data_q.push_back(fb_writedata);
            end
         end else begin
            fb_waitrequest = 1'b0; stalling = 1'b0;
         end
         if (blitter_finished) begin
            fin_cnt++; fin_cyc = cyc;
            chk("busy_during_done", 32'(busy), 32'd1);
         end
         if (prev_fin) chk("busy_after_done", 32'(busy), 32'd0);
         prev_fin = blitter_finished;
      end
   end

   // ---------------- vectors ----------------
   typedef struct {
      logic [25:0] spr;
      int xs, ys, dx, dy, lat, stall;
      int exp_rd, exp_wr, exp_first, exp_last;
   } vec_t;

   vec_t vt [7];

`ifdef BLIT_TRANSPARENCY_EN
   localparam int TR_WR = 2;
`else
   localparam int TR_WR = 3;
`endif

   task automatic chk_outputs_zero(input string name);
      chk(name, 32'(|{rd_req, rd_addr, fb_write, fb_address, fb_writedata,
                      blitter_finished, busy}), 32'd0);
   endtask

   // Runs one blit; dup >= 0 fires a second (to-be-ignored) start dup cycles
   // after the real start was released.
   task automatic run_blit(input string name, input vec_t v, input int dup, output int lat);
      int rd0, fin0, scyc, idx;
      logic done;
      rd_lat = v.lat; stall_n = v.stall;
      @(posedge Clk); #2;
      scnt = stall_n; rd0 = rd_cnt; fin0 = fin_cnt;
      wr_addr_q.delete(); wr_data_q.delete();
      sprite_address = v.spr; x_size = 10'(v.xs); y_size = 10'(v.ys);
      dest_x = 10'(v.dx); dest_y = 10'(v.dy);
      blitter_start = 1'b1; scyc = cyc;
      @(posedge Clk); #2;
      blitter_start = 1'b0;
      done = 1'b0;
      for (int i = 0; i < 4000 && !done; i++) begin
         if (fin_cnt != fin0) done = 1'b1;
         else begin
            if (i == dup) begin
               blitter_start = 1'b1; x_size = 10'd5; y_size = 10'd5;
               dest_x = 10'd0; dest_y = 10'd0; sprite_address = 26'h3F0;
            end else blitter_start = 1'b0;
            @(posedge Clk); #2;
         end
      end
      blitter_start = 1'b0;
      chk({name, "_timeout"}, 32'(done), 32'd1);
      lat = fin_cyc - scyc;
      repeat (3) @(posedge Clk);
      #2;
      chk({name, "_reads"},  32'(rd_cnt - rd0), 32'(v.exp_rd));
      chk({name, "_writes"}, 32'(wr_addr_q.size()), 32'(v.exp_wr));
      chk({name, "_done_once"}, 32'(fin_cnt - fin0), 32'd1);
      chk({name, "_busy_low"}, 32'(busy), 32'd0);
      if (v.exp_wr > 0 && wr_addr_q.size() > 0) begin
         chk({name, "_first_addr"}, 32'(wr_addr_q[0]), 32'(v.exp_first));
         chk({name, "_last_addr"},  32'(wr_addr_q[wr_addr_q.size()-1]), 32'(v.exp_last));
      end
      // reference: walk the rectangle in row-major order
      idx = 0;
      for (int r = 0; r < v.ys; r++)
         for (int c = 0; c < v.xs; c++) begin
            int px, py;
            logic on;
            logic [15:0] d;
            px = v.dx + c; py = v.dy + r;
            d  = mem[10'((int'(v.spr) + r * v.xs + c) & 1023)];
            on = (px < W) && (py < H);
`ifdef BLIT_TRANSPARENCY_EN
            if (d == 16'hF81F) on = 1'b0;
`endif
            if (on) begin
               if (idx < wr_addr_q.size()) begin
                  chk({name, "_wr_addr"}, 32'(wr_addr_q[idx]), 32'(py * W + px));
                  chk({name, "_wr_data"}, 32'(wr_data_q[idx]), 32'(d));
               end
               idx++;
            end
         end
   endtask

   initial begin
      int lat, fin0;
      for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 7 + 3);
      mem[10'h100] = 16'h1111; mem[10'h101] = 16'h2222;
      mem[10'h102] = 16'h3333; mem[10'h103] = 16'h4444;
      mem[10'h300] = 16'h0001; mem[10'h301] = 16'hF81F; mem[10'h302] = 16'h0003;

      //          spr     xs ys  dx   dy  lat st  rd wr     first   last
      vt[0] = '{26'h100,  2, 2,  10,  20, 1, 0,  4, 4,     12810,  13451};
      vt[1] = '{26'h010,  0, 5,   0,   0, 1, 0,  0, 0,         0,      0};
      vt[2] = '{26'h040,  4, 2, 638, 479, 1, 0,  8, 2,    307198, 307199};
      vt[3] = '{26'h000,  3, 2,   0,   0, 2, 3,  6, 6,         0,    642};
      vt[4] = '{26'h020,  3, 0,   0,   0, 1, 0,  0, 0,         0,      0};
      vt[5] = '{26'h200,  3, 1,   5,   0, 1, 0,  3, 3,         5,      7};
      vt[6] = '{26'h300,  3, 1,   1,   1, 1, 1,  3, TR_WR,   641,    643};

      // reset state
      #3;
      chk_outputs_zero("reset_outputs");
      repeat (3) @(posedge Clk);
      #2 Reset_n = 1'b1;
      #1 chk_outputs_zero("post_reset_outputs");

      for (int k = 0; k < 7; k++) begin
         run_blit($sformatf("vec%0d", k), vt[k], -1, lat);
         if (k == 1) chk("zero_size_latency", 32'(lat >= 1 && lat <= 2), 32'd1);
      end

      // second start while busy is ignored
      run_blit("start_busy", vt[0], 3, lat);
      // second start landing in DONE is ignored
      run_blit("start_done", vt[1], 0, lat);

      // reset in the middle of an 8x8 blit
      rd_lat = 1; stall_n = 0;
      @(posedge Clk); #2;
      sprite_address = 26'h080; x_size = 10'd8; y_size = 10'd8;
      dest_x = 10'd100; dest_y = 10'd50; blitter_start = 1'b1;
      @(posedge Clk); #2 blitter_start = 1'b0;
      repeat (40) @(posedge Clk);
      #3;
      chk("busy_before_reset", 32'(busy), 32'd1);
      fin0 = fin_cnt;
      Reset_n = 1'b0;
      #1 chk_outputs_zero("async_reset_outputs");
      repeat (2) @(posedge Clk);
      #2 Reset_n = 1'b1;
      repeat (10) @(posedge Clk);
      #2;
      chk("no_done_after_reset", 32'(fin_cnt - fin0), 32'd0);
      chk_outputs_zero("idle_after_reset");
      run_blit("after_reset", vt[0], -1, lat);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
